// File: rtl/dfi_phy_pkg.sv
// Shared DFI/PHY definitions: command bit positions, NOP/reset command and latency limits.
package dfi_phy_pkg;

    localparam int unsigned CmdCsN  = 0;
    localparam int unsigned CmdRasN = 1;
    localparam int unsigned CmdCasN = 2;
    localparam int unsigned CmdWeN  = 3;
    localparam logic [3:0]  CmdNop  = 4'b1111;

    localparam int unsigned RdLatMin       = 1;
    localparam int unsigned RdLatMaxMargin = 0;
    localparam int unsigned WrLatMin       = 2;
    localparam int unsigned WrLatMaxMargin = 1;
    localparam int unsigned RstLat         = 2;

    function automatic int unsigned clamp_lat(int unsigned val, int unsigned lo, int unsigned hi);
        if (val < lo) return lo;
        if (val > hi) return hi;
        return val;
    endfunction

endpackage

// File: rtl/dfi_phase_ctrl_if.sv
// DFI-side and PHY-side signal bundle for dfi_phase_ctrl.
// Carries rd_beats only when DFI_PHASE_CTRL_RDCNT_EN is defined.
interface dfi_phase_ctrl_if #(
    parameter int unsigned NPHASES = 2,
    parameter int unsigned NUM_AD  = 13,
    parameter int unsigned NUM_BA  = 2,
    parameter int unsigned LAT_W   = 4
);
    logic [NPHASES*NUM_AD-1:0] dfi_address;
    logic [NPHASES*NUM_BA-1:0] dfi_bank;
    logic [NPHASES-1:0]        dfi_cs_n, dfi_cke, dfi_ras_n, dfi_cas_n, dfi_we_n;
    logic [NPHASES-1:0]        dfi_wrdata_en, dfi_rddata_en;
    logic [LAT_W-1:0]          rdlat, wrlat;
    logic [NPHASES*NUM_AD-1:0] phy_address;
    logic [NPHASES*NUM_BA-1:0] phy_bank;
    logic [NPHASES-1:0]        phy_cs_n, phy_cke, phy_ras_n, phy_cas_n, phy_we_n;
    logic [NPHASES-1:0]        phy_dq_oe, phy_dqs_oe, dfi_rddata_valid;
    logic                      lat_busy, turnaround_err;
`ifdef DFI_PHASE_CTRL_RDCNT_EN
    logic [15:0]               rd_beats;
`endif

    modport master (
`ifdef DFI_PHASE_CTRL_RDCNT_EN
        input  rd_beats,
`endif
        output dfi_address, dfi_bank, dfi_cs_n, dfi_cke, dfi_ras_n, dfi_cas_n, dfi_we_n,
        output dfi_wrdata_en, dfi_rddata_en, rdlat, wrlat,
        input  phy_address, phy_bank, phy_cs_n, phy_cke, phy_ras_n, phy_cas_n, phy_we_n,
        input  phy_dq_oe, phy_dqs_oe, dfi_rddata_valid, lat_busy, turnaround_err
    );

    modport slave (
`ifdef DFI_PHASE_CTRL_RDCNT_EN
        output rd_beats,
`endif
        input  dfi_address, dfi_bank, dfi_cs_n, dfi_cke, dfi_ras_n, dfi_cas_n, dfi_we_n,
        input  dfi_wrdata_en, dfi_rddata_en, rdlat, wrlat,
        output phy_address, phy_bank, phy_cs_n, phy_cke, phy_ras_n, phy_cas_n, phy_we_n,
        output phy_dq_oe, phy_dqs_oe, dfi_rddata_valid, lat_busy, turnaround_err
    );

endinterface

// File: rtl/dfi_en_delay.sv
// Per-phase enable delay line: stage k (k=1..MAX_LAT) holds the enable from k cycles ago.
module dfi_en_delay #(
    parameter int unsigned NPHASES = 2,
    parameter int unsigned MAX_LAT = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [NPHASES-1:0]         i_en,
    output logic [MAX_LAT*NPHASES-1:0] o_stages,
    output logic                       o_nonempty
);

    // Stage 1 sits in the lowest NPHASES bits.
    logic [MAX_LAT*NPHASES-1:0] r_sr;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sr <= '0;
        end else begin
            r_sr <= {r_sr[(MAX_LAT-1)*NPHASES-1:0], i_en};
        end
    end

    assign o_stages   = r_sr;
    assign o_nonempty = |r_sr;

endmodule

// File: rtl/dfi_phase_ctrl.sv
// DFI-to-PHY timing controller: registered command path, programmable read-valid and
// DQ/DQS output-enable timing, collision flag. Optional rd_beats via DFI_PHASE_CTRL_RDCNT_EN.
module dfi_phase_ctrl
    import dfi_phy_pkg::*;
#(
    parameter int unsigned NPHASES = 2,
    parameter int unsigned NUM_AD  = 13,
    parameter int unsigned NUM_BA  = 2,
    parameter int unsigned MAX_LAT = 8,
    parameter int unsigned LAT_W   = 4
) (
    input logic             sys_clk,
    input logic             sys_rst_n,
    dfi_phase_ctrl_if.slave bus
);

    logic [MAX_LAT*NPHASES-1:0] w_rd_stages, w_wr_stages;
    logic                       w_rd_nonempty, w_wr_nonempty;
    logic [NPHASES-1:0]         w_rd_taps [0:MAX_LAT];
    logic [NPHASES-1:0]         w_wr_taps [0:MAX_LAT];
    logic [NPHASES-1:0]         w_rd_next, w_dq_next;
    logic                       w_dqs_next, w_busy, w_busy_next;
    logic [LAT_W-1:0]           r_rdlat, r_wrlat;
    logic [NPHASES-1:0]         r_rd_valid, r_dq_oe, r_dqs_oe;
    logic                       r_lat_busy, r_err;

    dfi_en_delay #(.NPHASES(NPHASES), .MAX_LAT(MAX_LAT)) u_rd_line (
        .i_clk      (sys_clk),
        .i_rst_n    (sys_rst_n),
        .i_en       (bus.dfi_rddata_en),
        .o_stages   (w_rd_stages),
        .o_nonempty (w_rd_nonempty)
    );

    dfi_en_delay #(.NPHASES(NPHASES), .MAX_LAT(MAX_LAT)) u_wr_line (
        .i_clk      (sys_clk),
        .i_rst_n    (sys_rst_n),
        .i_en       (bus.dfi_wrdata_en),
        .o_stages   (w_wr_stages),
        .o_nonempty (w_wr_nonempty)
    );

    assign w_rd_taps[0] = bus.dfi_rddata_en;
    assign w_wr_taps[0] = bus.dfi_wrdata_en;
    for (genvar k = 1; k <= MAX_LAT; k++) begin : g_taps
        assign w_rd_taps[k] = w_rd_stages[(k-1)*NPHASES +: NPHASES];
        assign w_wr_taps[k] = w_wr_stages[(k-1)*NPHASES +: NPHASES];
    end

    // Outputs are registered, so select the tap one stage earlier than the visible latency.
    always_comb begin
        w_rd_next  = '0;
        w_dq_next  = '0;
        w_dqs_next = 1'b0;
        for (int k = 0; k <= int'(MAX_LAT); k++) begin
            if (k == int'(r_rdlat) - 1) w_rd_next = w_rd_taps[k];
            if (k == int'(r_wrlat) - 1) w_dq_next = w_wr_taps[k];
            if (k >= int'(r_wrlat) - 2 && k <= int'(r_wrlat)) begin
                w_dqs_next = w_dqs_next | (|w_wr_taps[k]);
            end
        end
    end

    assign w_busy = w_rd_nonempty | w_wr_nonempty | (|bus.dfi_rddata_en) | (|bus.dfi_wrdata_en);
    // Registered lat_busy equals the occupancy of the stages visible in the current cycle.
    assign w_busy_next = (|bus.dfi_rddata_en) | (|w_rd_stages[(MAX_LAT-1)*NPHASES-1:0]) |
                         (|bus.dfi_wrdata_en) | (|w_wr_stages[(MAX_LAT-1)*NPHASES-1:0]);

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            bus.phy_address <= '0;
            bus.phy_bank    <= '0;
            bus.phy_cs_n    <= {NPHASES{CmdNop[CmdCsN]}};
            bus.phy_ras_n   <= {NPHASES{CmdNop[CmdRasN]}};
            bus.phy_cas_n   <= {NPHASES{CmdNop[CmdCasN]}};
            bus.phy_we_n    <= {NPHASES{CmdNop[CmdWeN]}};
            bus.phy_cke     <= '0;
            r_rdlat         <= LAT_W'(RstLat);
            r_wrlat         <= LAT_W'(RstLat);
            r_rd_valid      <= '0;
            r_dq_oe         <= '0;
            r_dqs_oe        <= '0;
            r_lat_busy      <= 1'b0;
            r_err           <= 1'b0;
        end else begin
            bus.phy_address <= bus.dfi_address;
            bus.phy_bank    <= bus.dfi_bank;
            bus.phy_cs_n    <= bus.dfi_cs_n;
            bus.phy_ras_n   <= bus.dfi_ras_n;
            bus.phy_cas_n   <= bus.dfi_cas_n;
            bus.phy_we_n    <= bus.dfi_we_n;
            bus.phy_cke     <= bus.dfi_cke;
            if (!w_busy) begin
                r_rdlat <= LAT_W'(clamp_lat(32'(bus.rdlat), RdLatMin, MAX_LAT - RdLatMaxMargin));
                r_wrlat <= LAT_W'(clamp_lat(32'(bus.wrlat), WrLatMin, MAX_LAT - WrLatMaxMargin));
            end
            r_rd_valid <= w_rd_next;
            r_dq_oe    <= w_dq_next;
            r_dqs_oe   <= {NPHASES{w_dqs_next}};
            r_lat_busy <= w_busy_next;
            r_err      <= r_err | (w_dqs_next & (|w_rd_next));
        end
    end

    assign bus.dfi_rddata_valid = r_rd_valid;
    assign bus.phy_dq_oe        = r_dq_oe;
    assign bus.phy_dqs_oe       = r_dqs_oe;
    assign bus.lat_busy         = r_lat_busy;
    assign bus.turnaround_err   = r_err;

`ifdef DFI_PHASE_CTRL_RDCNT_EN
    logic [15:0] r_rd_beats;
    logic [16:0] w_beats_sum;

    assign w_beats_sum = {1'b0, r_rd_beats} + 17'($countones(w_rd_next));

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_rd_beats <= '0;
        end else begin
            r_rd_beats <= w_beats_sum[16] ? 16'hFFFF : w_beats_sum[15:0];
        end
    end

    assign bus.rd_beats = r_rd_beats;
`endif

endmodule
